// File: rtl/pipelined_addsub_if.sv
// Valid/ready stream bundle for pipelined_addsub: operation in, result and flags out.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract, one WIDTH/STAGES carry slice per stage, valid/ready per stage.
// Optional saturation of overflowed results: define PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int SW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // a/b carry the still-unconsumed upper slices, s the completed lower slices,
  // c the carry into the next slice, o the overflow flag (last stage only).
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  stage_t            src  [STAGES];
  logic [STAGES-1:0] v_q, v_d, load, upv;
  logic [SW:0]       slice;

  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    src[0].a = bus.a;
    src[0].b = bus.sub ? ~bus.b : bus.b;
    src[0].s = '0;
    src[0].c = bus.sub ^ bus.cin;
    src[0].o = 1'b0;
    upv[0]   = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
      upv[k] = v_q[k-1];
    end

    // A stage can load if it or any stage downstream of it is empty, or the output drains.
    for (int k = 0; k < STAGES; k++) begin
      load[k] = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v_q[j]) load[k] = 1'b1;
      end
    end

    slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = st_q[k];
      v_d[k]  = load[k] ? upv[k] : v_q[k];
      slice   = {1'b0, src[k].a[k*SW +: SW]} + {1'b0, src[k].b[k*SW +: SW]}
              + {{SW{1'b0}}, src[k].c};
      if (load[k] && upv[k]) begin
        st_d[k]                = src[k];
        st_d[k].s[k*SW +: SW]  = slice[SW-1:0];
        st_d[k].c              = slice[SW];
      end
    end

    if (load[STAGES-1] && upv[STAGES-1]) begin
      st_d[STAGES-1].o = (src[STAGES-1].a[MSB] == src[STAGES-1].b[MSB]) &&
                         (st_d[STAGES-1].s[MSB] != src[STAGES-1].a[MSB]);
`ifdef PIPELINED_ADDSUB_SAT_EN
      if (st_d[STAGES-1].o) begin
        st_d[STAGES-1].s = src[STAGES-1].a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      // NOTE: the datapath is reset too, because the last stage drives sum/cout/ovf,
      // which must read zero after reset.
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      v_q  <= v_d;
      st_q <= st_d;
    end
  end

  assign bus.in_ready  = rst_n && load[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = st_q[STAGES-1].s;
  assign bus.cout      = st_q[STAGES-1].c;
  assign bus.ovf       = st_q[STAGES-1].o;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: scoreboard of model results, checked as results drain.
module tb_pipelined_addsub;
  localparam int W = 32;
  localparam int S = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus ();
  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, bad = 0, cyc = 0, stalls = 0, pops = 0, prev_pop = 0;
  bit   chk_lat = 1'b0, chk_gap = 1'b0, gap_first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: exact integer arithmetic, overflow from signed range.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    exp_t        e;
    logic [W:0]  u;
    longint      sr;
    longint      lim;
    lim = longint'(1) << (W-1);
    if (sub) begin
      u      = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
      e.cout = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
      sr     = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end else begin
      u      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.cout = u[W];
      sr     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    e.sum = u[W-1:0];
    e.ovf = (sr >= lim) || (sr < -lim);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (e.ovf) e.sum = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sum",  bus.sum,  mon_e.sum);
        check("cout", bus.cout, mon_e.cout);
        check("ovf",  bus.ovf,  mon_e.ovf);
        if (chk_lat) check("latency", cyc - mon_e.acc, S - 1);
        if (chk_gap) begin
          if (!gap_first) check("one_per_cycle", cyc - prev_pop, 1);
          gap_first = 1'b0;
          prev_pop  = cyc;
        end
      end
      pops++;
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    bit   r;
    int   n;
    exp_t e;
    e = model(a, b, cin, sub);
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    do begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    check("send_accept", r, 1);
    if (r) begin
      e.acc = cyc;
      sb.push_back(e);
    end
    stalls += n - 1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit           r;
    int           idx, p0, seen;
    exp_t         e;
    logic [W-1:0] hs;
    logic         hc, ho;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum",       bus.sum,       0);
    check("rst_cout",      bus.cout,      0);
    check("rst_ovf",       bus.ovf,       0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);
    @(posedge clk); #1;

    // Directed single operations with latency check
    chk_lat = 1'b1;
    send(32'h7fffffff, 32'h7fffffff, 1'b0, 1'b0); drain();
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1); drain();
    send(32'h12345678, 32'h12345670, 1'b1, 1'b0); drain();
    send(32'h00000123, 32'h00000124, 1'b0, 1'b1); drain();
    send(32'hffffffff, 32'h00000000, 1'b1, 1'b0); drain();
    send(32'h00000005, 32'h00000003, 1'b1, 1'b1); drain();

    // Back-to-back streaming
    stalls = 0; chk_gap = 1'b1; gap_first = 1'b1;
    for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
    drain();
    check("b2b_stalls", stalls, 0);
    chk_gap = 1'b0;

    // Back-pressure: fill the pipe, hold, then drain
    chk_lat = 1'b0;
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.a = W'(100 + idx); bus.b = W'(idx); bus.cin = 1'b0; bus.sub = 1'b0;
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk); #1;
      if (r) begin
        e = model(W'(100 + idx), W'(idx), 1'b0, 1'b0);
        e.acc = cyc;
        sb.push_back(e);
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepts", idx, 4);
    @(negedge clk);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_head_sum", bus.sum, sb[0].sum);
    hs = bus.sum; hc = bus.cout; ho = bus.ovf;
    repeat (3) @(negedge clk);
    check("bp_hold_sum",   bus.sum,       hs);
    check("bp_hold_cout",  bus.cout,      hc);
    check("bp_hold_ovf",   bus.ovf,       ho);
    check("bp_hold_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    p0 = pops;
    stalls = 0;
    bus.out_ready = 1'b1;
    send(32'd200, 32'd1, 1'b0, 1'b0);
    check("full_accept_and_drain", stalls, 0);
    drain();
    check("bp_drained", pops - p0, 5);

    // Reset with three operations in flight
    send(32'd1, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    send(32'd3, 32'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready,  0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_stale_result", seen, 0);
    @(posedge clk); #1;
    chk_lat = 1'b1;
    send(32'd420, 32'd420, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
